// File: rtl/uart_matmul_engine.sv
// NxN matrix-multiply engine: loads A then B from a byte stream, computes C = A*B with one MAC
// per cycle, streams C back MSB-first. Optional trailing XOR checksum byte: RESULT_CHECKSUM_EN.
module uart_matmul_engine #(
  parameter int N      = 2,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam int DIM_W  = (N > 1) ? $clog2(N) : 1;
  localparam int NB     = ACC_W / 8;
  localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [DIM_W-1:0]  LAST      = DIM_W'(N - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NB - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, SEND} state_t;
  state_t state, state_nx;

  logic [7:0]       a_mem [N][N];
  logic [7:0]       b_mem [N][N];
  logic [ACC_W-1:0] c_mem [N][N];

  logic [DIM_W-1:0]  ld_r, ld_c;
  logic [DIM_W-1:0]  ci, cj, ck;
  logic [DIM_W-1:0]  sr, sc;
  logic [BYTE_W-1:0] sb;
  logic [ACC_W-1:0]  acc, prod, sum, word;
  logic signed [15:0] sprod;
  logic [15:0]       uprod;
  logic [7:0]        res_byte;
  logic              ld_last, mac_last, res_last, accept, send_step, frame_end, done_q;

`ifdef RESULT_CHECKSUM_EN
  logic       chk_phase;
  logic [7:0] chk;
`endif

  assign ld_last  = (ld_r == LAST) && (ld_c == LAST);
  assign mac_last = (ci == LAST) && (cj == LAST) && (ck == LAST);
  assign res_last = (sr == LAST) && (sc == LAST) && (sb == LAST_BYTE);
  // accept is derived from state, not tx_valid, to keep the FSM comb block loop-free
  assign accept   = (state == SEND) && tx_ready;

`ifdef RESULT_CHECKSUM_EN
  assign send_step = accept && !chk_phase;
  assign frame_end = accept && chk_phase;
`else
  assign send_step = accept;
  assign frame_end = accept && res_last;
`endif

  assign done = done_q;

  // MAC datapath: product extended per signedness, sum wraps modulo 2^ACC_W
  always_comb begin
    sprod = 16'($signed(a_mem[ci][ck])) * 16'($signed(b_mem[ck][cj]));
    uprod = 16'(a_mem[ci][ck]) * 16'(b_mem[ck][cj]);
    if (SIGNED != 0) prod = {{(ACC_W-16){sprod[15]}}, sprod};
    else             prod = {{(ACC_W-16){1'b0}}, uprod};
    sum = ((ck == '0) ? '0 : acc) + prod;
  end

  // byte sb of the current result word, MSB first
  always_comb begin
    word     = c_mem[sr][sc];
    res_byte = '0;
    for (int n = 0; n < NB; n++)
      if (sb == BYTE_W'(NB - 1 - n)) res_byte = word[n*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    case (state)
      LOAD_A:  if (rx_valid && ld_last) state_nx = LOAD_B;
      LOAD_B:  if (rx_valid && ld_last) state_nx = COMPUTE;
      COMPUTE: begin
        busy = 1'b1;
        if (mac_last) state_nx = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
`ifdef RESULT_CHECKSUM_EN
        tx_data  = chk_phase ? chk : res_byte;
`else
        tx_data  = res_byte;
`endif
        if (frame_end) state_nx = LOAD_A;
      end
      default: state_nx = LOAD_A;
    endcase
  end

  // matrix storage: contents are don't-care after reset, so no reset branch
  always_ff @(posedge clk) begin
    if (!rst && rx_valid && state == LOAD_A) a_mem[ld_r][ld_c] <= rx_data;
    if (!rst && rx_valid && state == LOAD_B) b_mem[ld_r][ld_c] <= rx_data;
    if (!rst && state == COMPUTE && ck == LAST) c_mem[ci][cj] <= sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_r   <= '0;
      ld_c   <= '0;
      ci     <= '0;
      cj     <= '0;
      ck     <= '0;
      sr     <= '0;
      sc     <= '0;
      sb     <= '0;
      acc    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (rx_valid && (state == LOAD_A || state == LOAD_B)) begin
        if (ld_c == LAST) begin
          ld_c <= '0;
          ld_r <= (ld_r == LAST) ? '0 : ld_r + 1'b1;
        end else begin
          ld_c <= ld_c + 1'b1;
        end
      end
      if (state == COMPUTE) begin
        acc <= sum;
        if (ck == LAST) begin
          ck <= '0;
          if (cj == LAST) begin
            cj <= '0;
            ci <= (ci == LAST) ? '0 : ci + 1'b1;
          end else begin
            cj <= cj + 1'b1;
          end
        end else begin
          ck <= ck + 1'b1;
        end
      end
      if (send_step) begin
        if (sb == LAST_BYTE) begin
          sb <= '0;
          if (sc == LAST) begin
            sc <= '0;
            sr <= (sr == LAST) ? '0 : sr + 1'b1;
          end else begin
            sc <= sc + 1'b1;
          end
        end else begin
          sb <= sb + 1'b1;
        end
      end
    end
  end

`ifdef RESULT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      chk       <= 8'h00;
      chk_phase <= 1'b0;
    end else if (accept) begin
      if (chk_phase) begin
        chk       <= 8'h00;
        chk_phase <= 1'b0;
      end else begin
        chk <= chk ^ res_byte;
        if (res_last) chk_phase <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_matmul_engine.sv
// Directed bench for uart_matmul_engine: one signed and one unsigned instance (N=2, ACC_W=24).
module tb_uart_matmul_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] tx_data_s, tx_data_u;
  logic       tx_valid_s, tx_valid_u, busy_s, busy_u, done_s, done_u;
  logic       rx_valid_s, rx_valid_u, tx_ready_s, tx_ready_u;
  logic [7:0] cur_tx_data;
  logic       cur_tx_valid, cur_busy, cur_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_b [16];
  int exp_n;

`ifdef RESULT_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  always #5 clk = ~clk;

  assign rx_valid_s   = rx_valid & ~sel;
  assign rx_valid_u   = rx_valid & sel;
  assign tx_ready_s   = tx_ready & ~sel;
  assign tx_ready_u   = tx_ready & sel;
  assign cur_tx_data  = sel ? tx_data_u  : tx_data_s;
  assign cur_tx_valid = sel ? tx_valid_u : tx_valid_s;
  assign cur_busy     = sel ? busy_u     : busy_s;
  assign cur_done     = sel ? done_u     : done_s;

  uart_matmul_engine #(.N(2), .ACC_W(24), .SIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_s),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready_s),
    .busy(busy_s), .done(done_s));

  uart_matmul_engine #(.N(2), .ACC_W(24), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_u),
    .tx_data(tx_data_u), .tx_valid(tx_valid_u), .tx_ready(tx_ready_u),
    .busy(busy_u), .done(done_u));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input logic [95:0] p, input logic [7:0] c);
    for (int i = 0; i < 12; i++) exp_b[i] = p[95-8*i -: 8];
    exp_b[12] = c;
    exp_n = 12 + CHK;
  endtask

  // drives 8 bytes back-to-back; starts and ends at a negedge
  task automatic load(input logic [63:0] p);
    for (int i = 0; i < 8; i++) begin
      rx_data  = p[63-8*i -: 8];
      rx_valid = 1'b1;
      if (i == 7) begin
        check("busy_during_load", cur_busy, 0);
        check("tx_idle_during_load", cur_tx_valid, 0);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("busy_after_load", cur_busy, 1);
  endtask

  task automatic wait_send(input bit inject);
    int cnt;
    cnt = 0;
    while (!cur_tx_valid && cnt < 100) begin
      rx_data  = 8'hAA;
      rx_valid = inject && (cnt < 2);
      @(negedge clk);
      cnt++;
    end
    rx_valid = 1'b0;
    check("compute_cycles", cnt, 8);
  endtask

  task automatic collect(input int stall_at, input int inject_at);
    int w;
    tx_ready = 1'b1;
    for (int i = 0; i < exp_n; i++) begin
      w = 0;
      while (!cur_tx_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("no_bubble", w, 0);
      if (i == stall_at) begin
        tx_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check("stall_valid", cur_tx_valid, 1);
          check("stall_data", cur_tx_data, exp_b[i]);
        end
        tx_ready = 1'b1;
      end
      check("done_early", cur_done, 0);
      check($sformatf("byte%0d", i), cur_tx_data, exp_b[i]);
      rx_data  = 8'hAA;
      rx_valid = (i == inject_at);
      @(negedge clk);
      rx_valid = 1'b0;
    end
    check("done_pulse", cur_done, 1);
    check("valid_after_frame", cur_tx_valid, 0);
    check("busy_after_frame", cur_busy, 0);
    tx_ready = 1'b0;
    @(negedge clk);
    check("done_clear", cur_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, with rx traffic that must be ignored
    rst = 1'b1;
    rx_data = 8'h77;
    rx_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_valid", cur_tx_valid, 0);
    check("rst_tx_data", cur_tx_data, 8'h00);
    check("rst_busy", cur_busy, 0);
    check("rst_done", cur_done, 0);
    rx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // case 1
    set_exp(96'h000013_000016_00002B_000032, 8'h1C);
    load(64'h01020304_05060708);
    wait_send(1'b0);
    collect(-1, -1);

    // case 2: negative results
    set_exp(96'hFFFFFE_FFFFFD_FFFFFC_FFFFFB, 8'h04);
    load(64'hFF0000FF_02030405);
    wait_send(1'b0);
    collect(-1, -1);

    // case 4: backpressure at byte 5
    set_exp(96'h000013_000016_00002B_000032, 8'h1C);
    load(64'h01020304_05060708);
    wait_send(1'b0);
    collect(4, -1);

    // case 5: partial frame then reset
    for (int i = 0; i < 5; i++) begin
      rx_data  = 8'h10 + 8'(i);
      rx_valid = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx_valid", cur_tx_valid, 0);
    check("abort_busy", cur_busy, 0);
    load(64'h01020304_05060708);
    wait_send(1'b0);
    collect(-1, -1);

    // case 6: stray rx bytes in COMPUTE and SEND, then a clean frame
    load(64'h01020304_05060708);
    wait_send(1'b1);
    collect(-1, 2);
    set_exp(96'hFFFFFE_FFFFFD_FFFFFC_FFFFFB, 8'h04);
    load(64'hFF0000FF_02030405);
    wait_send(1'b0);
    collect(-1, -1);

    // unsigned instance
    sel = 1'b1;
    @(negedge clk);
    set_exp(96'h01FC02_01FC02_01FC02_01FC02, 8'h00);
    load(64'hFFFFFFFF_FFFFFFFF);
    wait_send(1'b0);
    collect(-1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
